// File: rtl/inv_cipher_pkg.sv
// inv_cipher_pkg: controller states, AES round-count constants and round-key index type
package inv_cipher_pkg;
  typedef enum logic [2:0] {IDLE, KEY, START, WAIT, DONE} fsm_e;
  localparam int NR_AES128 = 10;
  localparam int NR_AES192 = 12;
  localparam int NR_AES256 = 14;
  typedef logic [3:0] rk_idx_t;
endpackage

// File: rtl/inv_cipher_ctrl.sv
// inv_cipher_ctrl: sequences one AES inverse cipher over an external inverse round transform
// Define INV_CIPHER_ABORT_EN to add the abort_i port.
module inv_cipher_ctrl
  import inv_cipher_pkg::*;
#(
  parameter int NR = NR_AES128
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef INV_CIPHER_ABORT_EN
  input  logic         abort_i,
`endif
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] ct_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] pt_o,
  output logic         rk_req_o,
  output rk_idx_t      rk_idx_o,
  input  logic         rk_valid_i,
  input  logic [127:0] rk_i,
  output logic         tf_start_o,
  output logic         tf_bypass_mc_o,
  output logic [127:0] tf_s_o,
  input  logic [127:0] tf_s_i,
  input  logic         tf_done_i
);
  fsm_e         fsm_q, fsm_d;
  logic [127:0] st_q, st_d;
  rk_idx_t      rnd_q, rnd_d;
  logic         first_q, first_d, pend_q, pend_d, abort, kill;
`ifdef INV_CIPHER_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif
  assign kill = abort && fsm_q != IDLE;
  always_ff @(posedge clk) fsm_q <= !rst_n ? IDLE : fsm_d;
  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE:    fsm_d = in_valid_i ? KEY : IDLE;
      KEY:     fsm_d = rk_valid_i ? (rnd_q == '0 ? DONE : START) : KEY;
      START:   fsm_d = pend_q ? START : WAIT;
      WAIT:    fsm_d = tf_done_i ? KEY : WAIT;
      DONE:    fsm_d = out_ready_i ? IDLE : DONE;
      default: fsm_d = IDLE;
    endcase
    if (kill) fsm_d = IDLE;
  end
  always_comb begin
    in_ready_o     = fsm_q == IDLE;
    rk_req_o       = fsm_q == KEY;
    rk_idx_o       = rnd_q;
    tf_start_o     = fsm_q == START && !pend_q;
    tf_bypass_mc_o = first_q && (fsm_q == START || fsm_q == WAIT);
    tf_s_o         = st_q;
    out_valid_o    = fsm_q == DONE;
    pt_o           = st_q;
  end
  always_comb begin
    st_d    = st_q;
    rnd_d   = rnd_q;
    first_d = first_q;
    if (fsm_q == IDLE && in_valid_i) begin
      st_d    = ct_i;
      rnd_d   = rk_idx_t'(NR);
      first_d = 1'b1;
    end
    if (fsm_q == KEY && rk_valid_i) begin
      st_d  = st_q ^ rk_i;
      rnd_d = rnd_q == '0 ? rnd_q : rnd_q - 1'b1;
    end
    if (fsm_q == WAIT && tf_done_i) begin
      st_d    = tf_s_i;
      first_d = 1'b0;
    end
    if (kill) begin
      st_d    = '0;
      rnd_d   = '0;
      first_d = 1'b0;
    end
    // an aborted transform still owes one done pulse; hold the next START until it lands
    pend_d = kill && ((fsm_q == WAIT && !tf_done_i) || (fsm_q == START && !pend_q)) ? 1'b1 :
             tf_done_i ? 1'b0 : pend_q;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      st_q    <= '0;
      rnd_q   <= '0;
      first_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      rnd_q   <= rnd_d;
      first_q <= first_d;
      pend_q  <= pend_d;
    end
endmodule

// File: tb/tb_inv_cipher_ctrl.sv
// tb_inv_cipher_ctrl: scoreboard bench, NR=10 and NR=14 controllers with transform and key-store models
module tb_inv_cipher_ctrl;
  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  logic clk = 1'b0, rst_n;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic in_valid[2], in_ready[2], out_valid[2], out_ready[2], rk_req[2], rk_valid[2];
  logic tf_start[2], tf_byp[2], tf_done[2], inj_done[2], inj_rk[2], ign[2];
  logic [127:0] ct[2], pt[2], rk[2], tf_s_o[2], tf_si[2];
  logic [3:0] rk_idx[2];
`ifdef INV_CIPHER_ABORT_EN
  logic abort[2];
`endif
  logic [7:0] sb[256], isb[256];
  logic [127:0] rk_tab[3][15];
  logic [127:0] q0[$], q1[$];
  int ks_lat[2], nrv[2], acc_cyc[2], out_cyc[2], exp_idx[2], nst[2], nacc[2];
  logic lat_pend[2];
  int ksel, ntests = 0, nfail = 0;

  task automatic fail(input string nm);
    ntests++;
    nfail++;
    $display("FAIL %s: expected event did not occur within its cycle budget", nm);
  endtask
  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    ntests++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction
  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction
  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction
  function automatic logic [127:0] inv_tf(input logic [127:0] s, input logic byp);
    logic [7:0] a[16], b[16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
    if (!byp) begin
      for (int c = 0; c < 4; c++) begin
        b[4*c]   = gmul(a[4*c],8'h0e)^gmul(a[4*c+1],8'h0b)^gmul(a[4*c+2],8'h0d)^gmul(a[4*c+3],8'h09);
        b[4*c+1] = gmul(a[4*c],8'h09)^gmul(a[4*c+1],8'h0e)^gmul(a[4*c+2],8'h0b)^gmul(a[4*c+3],8'h0d);
        b[4*c+2] = gmul(a[4*c],8'h0d)^gmul(a[4*c+1],8'h09)^gmul(a[4*c+2],8'h0e)^gmul(a[4*c+3],8'h0b);
        b[4*c+3] = gmul(a[4*c],8'h0b)^gmul(a[4*c+1],8'h0d)^gmul(a[4*c+2],8'h09)^gmul(a[4*c+3],8'h0e);
      end
    end else b = a;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) a[r+4*c] = b[r+4*((c-r+4)%4)];
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = isb[a[i]];
    return o;
  endfunction
  task automatic expand(input int k, input logic [255:0] key, input int nk, input int nr);
    logic [31:0] w[60];
    logic [31:0] t;
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 4*(nr+1); i++) begin
      if (i < nk) w[i] = key[255-32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk > 6 && i % nk == 4) t = subw(t);
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= nr; r++) rk_tab[k][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    logic [2:0] pipe;
    logic [1:0] kc;
    logic [127:0] res, s_cap;
    logic byp_cap;
    inv_cipher_ctrl #(.NR(g == 0 ? 10 : 14)) dut (
      .clk(clk), .rst_n(rst_n),
`ifdef INV_CIPHER_ABORT_EN
      .abort_i(abort[g]),
`endif
      .in_valid_i(in_valid[g]), .in_ready_o(in_ready[g]), .ct_i(ct[g]),
      .out_valid_o(out_valid[g]), .out_ready_i(out_ready[g]), .pt_o(pt[g]),
      .rk_req_o(rk_req[g]), .rk_idx_o(rk_idx[g]), .rk_valid_i(rk_valid[g]), .rk_i(rk[g]),
      .tf_start_o(tf_start[g]), .tf_bypass_mc_o(tf_byp[g]), .tf_s_o(tf_s_o[g]),
      .tf_s_i(tf_si[g]), .tf_done_i(tf_done[g]));
    always_ff @(posedge clk) begin
      pipe <= rst_n ? {pipe[1:0], tf_start[g]} : 3'b000;
      kc <= (!rst_n || !rk_req[g] || rk_valid[g]) ? 2'd0 : kc + 2'd1;
      if (tf_start[g]) begin
        res     <= inv_tf(tf_s_o[g], tf_byp[g]);
        s_cap   <= tf_s_o[g];
        byp_cap <= tf_byp[g];
      end
    end
    assign tf_done[g]  = pipe[2] | inj_done[g];
    assign tf_si[g]    = inj_done[g] ? {4{32'hdeadbeef}} : res;
    assign rk_valid[g] = (rk_req[g] && int'(kc) >= ks_lat[g]) || inj_rk[g];
    assign rk[g] = inj_rk[g] ? {4{32'hbadc0de5}} : (g == 0 ? rk_tab[ksel][rk_idx[g]] : rk_tab[2][rk_idx[g]]);
    initial forever begin
      @(negedge clk);
      if (rst_n && pipe[2] && !ign[g]) begin
        chk("tf_s_stable", tf_s_o[g], s_cap);
        chk("bypass_held", tf_byp[g], byp_cap);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) for (int i = 0; i < 2; i++) begin
      if (in_valid[i] && in_ready[i]) begin
        acc_cyc[i] = cyc;
        exp_idx[i] = nrv[i];
        nst[i] = 0;
        lat_pend[i] = 1'b1;
        nacc[i]++;
      end
      if (rk_req[i] && rk_valid[i]) begin
        chk("rk_idx", rk_idx[i], exp_idx[i]);
        exp_idx[i]--;
      end
      if (tf_start[i]) begin
        chk("bypass_first", tf_byp[i], nst[i] == 0);
        nst[i]++;
      end
      if (out_valid[i] && lat_pend[i]) begin
        lat_pend[i] = 1'b0;
        if (ks_lat[i] == 0) chk("latency", cyc - acc_cyc[i] + 1, 5*nrv[i] + 3);
      end
      if (out_valid[i] && out_ready[i]) begin
        out_cyc[i] = cyc;
        chk("start_count", nst[i], nrv[i]);
        if ((i == 0 ? q0.size() : q1.size()) == 0) chk("unexpected_out", pt[i], '0);
        else chk("plaintext", pt[i], i == 0 ? q0.pop_front() : q1.pop_front());
      end
    end
  end

  task automatic send(input int i, input logic [127:0] c, input logic [127:0] p);
    int n;
    logic a;
    n = 0;
    if (i == 0) q0.push_back(p); else q1.push_back(p);
    in_valid[i] = 1'b1;
    ct[i] = c;
    do begin
      @(negedge clk);
      a = in_ready[i];
      @(posedge clk);
      #1;
      n++;
    end while (!a && n < 200);
    in_valid[i] = 1'b0;
    if (!a) fail("accept");
  endtask
  task automatic wait_done(input int i);
    int n;
    n = 0;
    while ((i == 0 ? q0.size() : q1.size()) != 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 400) fail("out_handshake");
    @(posedge clk);
    #1;
  endtask
  task automatic wait_start(input int i);
    int n;
    n = 0;
    while (!tf_start[i] && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) fail("tf_start");
  endtask
  task automatic chk_rst(input int i);
    chk("rst_in_ready", in_ready[i], 1'b1);
    chk("rst_out_valid", out_valid[i], 1'b0);
    chk("rst_rk_req", rk_req[i], 1'b0);
    chk("rst_rk_idx", rk_idx[i], 4'd0);
    chk("rst_tf_start", tf_start[i], 1'b0);
    chk("rst_bypass", tf_byp[i], 1'b0);
    chk("rst_pt", pt[i], '0);
    chk("rst_tf_s", tf_s_o[i], '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v, s;
    int n;
    for (int x = 0; x < 256; x++) begin
      v = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
      s = v ^ rl(v, 1) ^ rl(v, 2) ^ rl(v, 3) ^ rl(v, 4) ^ 8'h63;
      sb[x] = s;
      isb[s] = 8'(x);
    end
    expand(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
    expand(1, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 10);
    expand(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    nrv[0] = 10;
    nrv[1] = 14;
    ksel = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; ct[i] = '0; out_ready[i] = 1'b1;
      inj_done[i] = 1'b0; inj_rk[i] = 1'b0; ign[i] = 1'b0;
      ks_lat[i] = 0; nacc[i] = 0; nst[i] = 0; lat_pend[i] = 1'b0;
`ifdef INV_CIPHER_ABORT_EN
      abort[i] = 1'b0;
`endif
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_rst(0);
    chk_rst(1);
    send(0, C1_CT, C1_PT);
    wait_done(0);
    ksel = 1;
    send(0, B_CT, B_PT);
    wait_done(0);
    ksel = 0;
    send(1, C3_CT, C1_PT);
    wait_done(1);
    ks_lat[1] = 2;
    send(1, C3_CT, C1_PT);
    wait_done(1);
    // spurious done while fetching a key, spurious key while transforming
    ks_lat[0] = 2;
    send(0, C1_CT, C1_PT);
    inj_done[0] = 1'b1;
    @(posedge clk);
    #1 inj_done[0] = 1'b0;
    wait_start(0);
    @(posedge clk);
    #1 inj_rk[0] = 1'b1;
    @(posedge clk);
    #1 inj_rk[0] = 1'b0;
    wait_done(0);
    ks_lat[0] = 0;
    out_ready[0] = 1'b0;
    send(0, C1_CT, C1_PT);
    n = 0;
    while (!out_valid[0] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) fail("stall_out_valid");
    for (int k = 0; k < 20; k++) begin
      chk("stall_valid", out_valid[0], 1'b1);
      chk("stall_pt", pt[0], C1_PT);
      chk("stall_in_ready", in_ready[0], 1'b0);
      @(posedge clk);
      #1;
    end
    out_ready[0] = 1'b1;
    wait_done(0);
    chk("idle_after_accept", in_ready[0], 1'b1);
    n = nacc[0];
    q0.push_back(C1_PT);
    q0.push_back(C1_PT);
    in_valid[0] = 1'b1;
    ct[0] = C1_CT;
    for (int k = 0; k < 200 && nacc[0] < n + 2; k++) begin
      @(posedge clk);
      #1;
    end
    in_valid[0] = 1'b0;
    if (nacc[0] < n + 2) fail("b2b_accept");
    chk("b2b_gap", acc_cyc[0], out_cyc[0] + 1);
    wait_done(0);
    send(0, B_CT, B_PT);
    ksel = 1;
    n = 0;
    while (nst[0] < 5 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) fail("round5");
    rst_n = 1'b0;
    q0.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk_rst(0);
    send(0, B_CT, B_PT);
    wait_done(0);
    ksel = 0;
`ifdef INV_CIPHER_ABORT_EN
    ign[0] = 1'b1;
    send(0, C1_CT, C1_PT);
    wait_start(0);
    @(posedge clk);
    #1 abort[0] = 1'b1;
    @(posedge clk);
    #1 abort[0] = 1'b0;
    q0.delete();
    chk("abort_in_ready", in_ready[0], 1'b1);
    chk("abort_rk_req", rk_req[0], 1'b0);
    chk("abort_out_valid", out_valid[0], 1'b0);
    chk("abort_state", tf_s_o[0], '0);
    send(0, C1_CT, C1_PT);
    wait_done(0);
    ign[0] = 1'b0;
`endif
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
